cla4_bist_checker: RTL and testbench
====================================

// Module: cla4_bist_checker
// PURPOSE
//  Synthesizable built-in self-test engine for the CLA4 carry-lookahead adder slice.
//  Drives the adder's operand/carry-in side (A, B, Ci) and receives its result side (S, Co, PG, GG).
//  Sweeps all 2^(2*WIDTH+1) input vectors, compares each result against an internal golden model,
//  and reports pass/fail, a saturating error count and the first failing vector.
//  Sits beside the adder as a power-on or on-demand self-test controller.
// PARAMETERS
//  WIDTH      4   adder operand width; golden model and vector counter scale with it
//  SETTLE     1   cycles operands are held before sampling results (legal range 1..15)
//  ERR_CNT_W  16  width of the saturating error counter
// PORTS
//  clk             in   1           rising-edge clock
//  rst             in   1           asynchronous, active-high reset
//  start           in   1           one-cycle pulse: begin sweep (honoured in IDLE or DONE only)
//  A               out  WIDTH       operand A to adder
//  B               out  WIDTH       operand B to adder
//  Ci              out  1           carry-in to adder
//  S               in   WIDTH       adder sum
//  Co              in   1           adder carry-out
//  PG              in   1           adder group propagate
//  GG              in   1           adder group generate
//  busy            out  1           sweep in progress
//  done            out  1           sweep finished; held until next start or reset
//  pass            out  1           valid when done=1; 1 iff err_count==0
//  err_count       out  ERR_CNT_W   mismatching vectors, saturates at all-ones
//  first_fail_vec  out  2*WIDTH+1   {Ci,A,B} of first mismatch; 0 if none
// BEHAVIOUR
//  Reset (async): state=IDLE; A, B, Ci, busy, done, pass, err_count, first_fail_vec all 0.
//  Vector index v (2*WIDTH+1 bits) maps to outputs as {Ci,A,B} = v; v runs 0 .. 2^(2*WIDTH+1)-1.
//  Golden model: P=A^B, G=A&B; {Co,S}=A+B+Ci; PG=&P;
//    GG = G[W-1] | P[W-1]&G[W-2] | ... | P[W-1:1] all set & G[0].
//  FSM states: IDLE, HOLD, CHECK, DONE.
//   IDLE/DONE + start: v<=0; err_count<=0; first_fail_vec<=0; done<=0; pass<=0; busy<=1; wait<=0; go to HOLD.
//   HOLD: {Ci,A,B} driven from v; wait increments; after SETTLE HOLD cycles, go to CHECK.
//   CHECK (1 cycle, operands still driven):
//    - Compare {S,Co,PG,GG} against golden(v).
//    - On mismatch: err_count+1 (saturating); if err_count was 0, first_fail_vec<=v.
//    - If v is the last vector: go to DONE; else v<=v+1, wait<=0, go to HOLD.
//   DONE: busy=0, done=1, pass=(err_count==0). A/B/Ci hold the last vector.
//  Cost: SETTLE+1 cycles per vector; busy is high for exactly 2^(2W+1)*(SETTLE+1) cycles.
//   WIDTH=4, SETTLE=1: 1024 cycles.
//  start while busy: ignored; no restart and no counter disturbance.
//  rst during a sweep: immediate return to reset values; the next start sweeps from v=0.
//  Adder is treated as combinational; results are sampled only in CHECK, never in HOLD.
//  No X is propagated: compare uses == on registered expectations (X on S counts as mismatch in sim).
// TESTING (WIDTH=4, SETTLE=1 unless stated)
//  1. Correct CLA4 attached, one start pulse -> busy 1024 cycles, then done=1, pass=1,
//     err_count=0, first_fail_vec=0.
//  2. S[0] forced 0 -> done, pass=0, err_count=256, first_fail_vec=9'h001.
//  3. GG forced 0 -> err_count=240, first_fail_vec=9'h01F (A=1, B=15, Ci=0).
//  4. ERR_CNT_W=4, S[0] forced 0 -> err_count saturates at 15; first_fail_vec=9'h001.
//  5. start re-pulsed at cycle 300 of a sweep -> ignored, done still at cycle 1024.
//     rst at cycle 500 -> all outputs 0 at once; a new start completes a full clean sweep.
//  6. SETTLE=3, correct adder -> busy exactly 2048 cycles, pass=1.
//     Checker asserts A/B/Ci are stable across each HOLD+CHECK window.

Source files
------------

// File: rtl/cla4_bist_checker.sv
// ============================================================================
// cla4_bist_checker
// ----------------------------------------------------------------------------
// Built-in self-test engine for a CLA4 carry-lookahead adder slice.
// Sweeps every {Ci,A,B} input vector into the adder, waits SETTLE cycles,
// then compares the adder's {S,Co,PG,GG} against an internal golden model.
// Reports pass/fail, a saturating mismatch count and the first failing vector.
//
// Parameters:
//   WIDTH      adder operand width
//   SETTLE     cycles operands are held before the result is sampled (1..15)
//   ERR_CNT_W  width of the saturating error counter
//
// Ports:
//   i_clk             rising-edge clock
//   i_rst             asynchronous active-high reset
//   i_start           one-cycle pulse, starts a sweep from IDLE or DONE
//   o_a, o_b, o_ci    operands / carry-in driven to the adder
//   i_s, i_co         adder sum and carry-out
//   i_pg, i_gg        adder group propagate / group generate
//   o_busy            sweep in progress
//   o_done            sweep finished, held until next start or reset
//   o_pass            valid with o_done, high when no mismatch was seen
//   o_err_count       number of mismatching vectors, saturates at all-ones
//   o_first_fail_vec  {Ci,A,B} of the first mismatch, zero if none
// ============================================================================
module cla4_bist_checker #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 1,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic [WIDTH-1:0]     o_a,
    output logic [WIDTH-1:0]     o_b,
    output logic                 o_ci,
    input  logic [WIDTH-1:0]     i_s,
    input  logic                 i_co,
    input  logic                 i_pg,
    input  logic                 i_gg,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [2*WIDTH:0]     o_first_fail_vec
);

    localparam int              VW          = 2 * WIDTH + 1;
    localparam logic [VW-1:0]   LAST_VEC    = '1;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        CHECK,
        DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [VW-1:0]          r_vec;
    logic [3:0]             r_wait;
    logic [ERR_CNT_W-1:0]   r_err_count;
    logic [VW-1:0]          r_first_fail;

    logic [WIDTH-1:0]       w_a;
    logic [WIDTH-1:0]       w_b;
    logic                   w_ci;
    logic [WIDTH-1:0]       w_p;
    logic [WIDTH-1:0]       w_g;
    logic [WIDTH:0]         w_sum;
    logic                   w_gg;
    logic [WIDTH+2:0]       w_expected;
    logic [WIDTH+2:0]       w_actual;
    logic                   w_mismatch;
    logic                   w_start_ok;
    logic                   w_last_vec;
    logic                   w_settled;

    // The vector register is split as {Ci,A,B}; the golden model works from
    // the register itself so the expectation is stable for the whole window.
    assign w_ci  = r_vec[VW-1];
    assign w_a   = r_vec[2*WIDTH-1:WIDTH];
    assign w_b   = r_vec[WIDTH-1:0];
    assign w_p   = w_a ^ w_b;
    assign w_g   = w_a & w_b;
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_ci};

    // Group generate built as a ripple from bit 0 upward:
    // gg_i = G[i] | P[i] & gg_(i-1).
    always_comb begin
        w_gg = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_gg = w_g[i] | (w_p[i] & w_gg);
        end
    end

    assign w_expected = {w_sum[WIDTH-1:0], w_sum[WIDTH], &w_p, w_gg};
    assign w_actual   = {i_s, i_co, i_pg, i_gg};

    // Mismatch defaults to 1 so that an unknown adder output is counted as a
    // failure rather than silently accepted.
    always_comb begin
        w_mismatch = 1'b1;
        if (w_actual == w_expected) begin
            w_mismatch = 1'b0;
        end
    end

    assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_vec = (r_vec == LAST_VEC);
    assign w_settled  = (r_wait == SETTLE_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_ok) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (w_settled) begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                w_next_state = w_last_vec ? DONE : HOLD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_pass = 1'b0;
        case (r_state)
            HOLD, CHECK: o_busy = 1'b1;
            DONE: begin
                o_done = 1'b1;
                o_pass = (r_err_count == '0);
            end
            default: ;
        endcase
    end

    // Sweep datapath. The vector is left untouched in DONE so the adder keeps
    // seeing the last vector after the sweep.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vec        <= '0;
            r_wait       <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_vec        <= '0;
                        r_wait       <= '0;
                        r_err_count  <= '0;
                        r_first_fail <= '0;
                    end
                end
                HOLD: begin
                    if (!w_settled) begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != '1) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                        if (r_err_count == '0) begin
                            r_first_fail <= r_vec;
                        end
                    end
                    if (!w_last_vec) begin
                        r_vec  <= r_vec + 1'b1;
                        r_wait <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ci             = w_ci;
    assign o_a              = w_a;
    assign o_b              = w_b;
    assign o_err_count      = r_err_count;
    assign o_first_fail_vec = r_first_fail;

endmodule

// File: tb/tb_cla4_bist_checker.sv
// ============================================================================
// tb_cla4_bist_checker
// ----------------------------------------------------------------------------
// Two checker instances: dut1 (WIDTH=4, SETTLE=1, ERR_CNT_W=16) and
// dut2 (WIDTH=4, SETTLE=3, ERR_CNT_W=4). Each drives a behavioural adder
// whose fault mode is selected per sweep. Expected sweep results are pushed
// into a per-instance queue when a sweep is started and popped when the
// instance reports done.
// ============================================================================
module tb_cla4_bist_checker;

    typedef struct {
        int         err;
        logic [8:0] first;
        logic       pass;
        int         cycles;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        start1, start2;
    logic [3:0]  a1, b1, s1, a2, b2, s2;
    logic        ci1, co1, pg1, gg1, ci2, co2, pg2, gg2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] err1;
    logic [3:0]  err2;
    logic [8:0]  ffv1, ffv2;

    int          mode1, mode2;
    int          checks;
    int          errors;
    int          mon1, mon2;
    int          monFails;
    exp_t        q1[$];
    exp_t        q2[$];

    cla4_bist_checker #(.WIDTH(4), .SETTLE(1), .ERR_CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1),
        .o_a(a1), .o_b(b1), .o_ci(ci1),
        .i_s(s1), .i_co(co1), .i_pg(pg1), .i_gg(gg1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_count(err1), .o_first_fail_vec(ffv1)
    );

    cla4_bist_checker #(.WIDTH(4), .SETTLE(3), .ERR_CNT_W(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2),
        .o_a(a2), .o_b(b2), .o_ci(ci2),
        .i_s(s2), .i_co(co2), .i_pg(pg2), .i_gg(gg2),
        .o_busy(busy2), .o_done(done2), .o_pass(pass2),
        .o_err_count(err2), .o_first_fail_vec(ffv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference adder result packed as {S,Co,PG,GG}. GG is the carry-out of
    // A+B with no carry-in; PG means every bit position propagates.
    function automatic logic [6:0] ref_adder(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [4:0] sum;
        logic [4:0] gen;
        sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        gen = {1'b0, a} + {1'b0, b};
        return {sum[3:0], sum[4], ((a ^ b) == 4'hF), gen[4]};
    endfunction

    // Fault modes: 0 healthy, 1 S[0] stuck 0, 2 GG stuck 0,
    // 3 Co inverted when A==B, 4 PG inverted only for the last vector.
    function automatic logic [6:0] fault_adder(input int mode, input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [6:0] r;
        r = ref_adder(a, b, ci);
        case (mode)
            1: r[3] = 1'b0;
            2: r[0] = 1'b0;
            3: if (a == b) r[2] = ~r[2];
            4: if (a == 4'hF && b == 4'hF && ci) r[1] = ~r[1];
            default: ;
        endcase
        return r;
    endfunction

    function automatic exp_t sweep_model(input int mode, input int satMax, input int settle);
        exp_t       e;
        logic [8:0] v;
        e.err   = 0;
        e.first = '0;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            if (fault_adder(mode, v[7:4], v[3:0], v[8]) != ref_adder(v[7:4], v[3:0], v[8])) begin
                if (e.err == 0) e.first = v;
                if (e.err < satMax) e.err++;
            end
        end
        e.pass   = (e.err == 0);
        e.cycles = 512 * (settle + 1);
        return e;
    endfunction

    always_comb {s1, co1, pg1, gg1} = fault_adder(mode1, a1, b1, ci1);
    always_comb {s2, co2, pg2, gg2} = fault_adder(mode2, a2, b2, ci2);

    // While busy, the driven vector must equal (busy cycles so far)/(SETTLE+1):
    // this covers sweep order and operand stability across HOLD+CHECK.
    always @(negedge clk) begin
        if (rst || !busy1) begin
            mon1 = 0;
        end else begin
            checks++;
            if ({ci1, a1, b1} !== 9'(mon1 / 2)) begin
                errors++;
                if (monFails < 8) $display("[TB] FAIL vec_order1: got %h expected %h", {ci1, a1, b1}, 9'(mon1 / 2));
                monFails++;
            end
            mon1++;
        end
    end

    always @(negedge clk) begin
        if (rst || !busy2) begin
            mon2 = 0;
        end else begin
            checks++;
            if ({ci2, a2, b2} !== 9'(mon2 / 4)) begin
                errors++;
                if (monFails < 8) $display("[TB] FAIL vec_order2: got %h expected %h", {ci2, a2, b2}, 9'(mon2 / 4));
                monFails++;
            end
            mon2++;
        end
    end

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1'b1;
        else            start2 = 1'b1;
    endtask

    // Counts busy cycles until done; optionally re-pulses start at a given
    // busy-cycle count. Clears any pending start pulse on its first edge.
    task automatic wait_done(input int which, input int repulseAt, output int cycles, output bit timedOut);
        bit stop;
        int n;
        cycles   = 0;
        timedOut = 1'b0;
        stop     = 1'b0;
        n        = 0;
        while (!stop && n < 5000) begin
            @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
            if ((which == 1) ? busy1 : busy2) cycles++;
            if ((which == 1) ? done1 : done2) stop = 1'b1;
            else if (cycles == repulseAt) begin
                if (which == 1) start1 = 1'b1;
                else            start2 = 1'b1;
            end
            n++;
        end
        if (!stop) timedOut = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags1: got %b%b%b expected 000", busy1, done1, pass1); end
        checks++; if (err1 !== 16'd0 || ffv1 !== 9'd0) begin errors++; $display("[TB] FAIL reset_counts1: got %0d/%h expected 0/000", err1, ffv1); end
        checks++; if ({ci1, a1, b1} !== 9'd0) begin errors++; $display("[TB] FAIL reset_operands1: got %h expected 000", {ci1, a1, b1}); end
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || err2 !== 4'd0 || ffv2 !== 9'd0) begin errors++; $display("[TB] FAIL reset_dut2: got %b%b %0d %h expected 00 0 000", busy2, done2, err2, ffv2); end
    endtask

    task automatic test_clean_sweep();
        exp_t e; int cyc; bit to;
        mode1 = 0;
        q1.push_back(sweep_model(0, 65535, 1));
        pulse_start(1);
        wait_done(1, -1, cyc, to);
        e = q1.pop_front();
        checks++; if (to) begin errors++; $display("[TB] FAIL clean_timeout: got no done expected done within budget"); end
        checks++; if (cyc != e.cycles) begin errors++; $display("[TB] FAIL clean_cycles: got %0d expected %0d", cyc, e.cycles); end
        checks++; if (int'(err1) != e.err || ffv1 !== e.first) begin errors++; $display("[TB] FAIL clean_result: got %0d/%h expected %0d/%h", err1, ffv1, e.err, e.first); end
        checks++; if (pass1 !== e.pass || busy1 !== 1'b0) begin errors++; $display("[TB] FAIL clean_pass: got pass=%b busy=%b expected pass=%b busy=0", pass1, busy1, e.pass); end
        checks++; if ({ci1, a1, b1} !== 9'h1FF) begin errors++; $display("[TB] FAIL clean_hold_last: got %h expected 1ff", {ci1, a1, b1}); end
    endtask

    task automatic test_fault(input int mode, input string name);
        exp_t e; int cyc; bit to;
        mode1 = mode;
        q1.push_back(sweep_model(mode, 65535, 1));
        pulse_start(1);
        wait_done(1, -1, cyc, to);
        e = q1.pop_front();
        checks++; if (to || cyc != e.cycles) begin errors++; $display("[TB] FAIL %s_cycles: got %0d (timeout=%0b) expected %0d", name, cyc, to, e.cycles); end
        checks++; if (int'(err1) != e.err) begin errors++; $display("[TB] FAIL %s_err_count: got %0d expected %0d", name, err1, e.err); end
        checks++; if (ffv1 !== e.first) begin errors++; $display("[TB] FAIL %s_first_fail: got %h expected %h", name, ffv1, e.first); end
        checks++; if (pass1 !== e.pass || done1 !== 1'b1) begin errors++; $display("[TB] FAIL %s_pass: got pass=%b done=%b expected pass=%b done=1", name, pass1, done1, e.pass); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int cyc; bit to;
        mode1 = 4;
        q1.push_back(sweep_model(4, 65535, 1));
        pulse_start(1);
        @(negedge clk);
        start1 = 1'b0;
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || pass1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart_flags: got %b%b%b expected 100", busy1, done1, pass1); end
        checks++; if (err1 !== 16'd0 || ffv1 !== 9'd0) begin errors++; $display("[TB] FAIL b2b_restart_clear: got %0d/%h expected 0/000", err1, ffv1); end
        wait_done(1, -1, cyc, to);
        e = q1.pop_front();
        // one busy cycle was consumed by the restart checks above
        checks++; if (to || cyc + 1 != e.cycles) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d expected %0d", cyc + 1, e.cycles); end
        checks++; if (int'(err1) != e.err || ffv1 !== e.first || pass1 !== e.pass) begin errors++; $display("[TB] FAIL b2b_result: got %0d/%h/%b expected %0d/%h/%b", err1, ffv1, pass1, e.err, e.first, e.pass); end
    endtask

    task automatic test_restart_ignored();
        exp_t e; int cyc; bit to;
        mode1 = 3;
        q1.push_back(sweep_model(3, 65535, 1));
        pulse_start(1);
        wait_done(1, 300, cyc, to);
        e = q1.pop_front();
        checks++; if (to || cyc != e.cycles) begin errors++; $display("[TB] FAIL restart_cycles: got %0d expected %0d", cyc, e.cycles); end
        checks++; if (int'(err1) != e.err || ffv1 !== e.first || pass1 !== e.pass) begin errors++; $display("[TB] FAIL restart_result: got %0d/%h/%b expected %0d/%h/%b", err1, ffv1, pass1, e.err, e.first, e.pass); end
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e; int cyc; bit to;
        mode1 = 1;
        pulse_start(1);
        @(negedge clk);
        start1 = 1'b0;
        repeat (499) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags: got %b%b%b expected 000", busy1, done1, pass1); end
        checks++; if (err1 !== 16'd0 || ffv1 !== 9'd0 || {ci1, a1, b1} !== 9'd0) begin errors++; $display("[TB] FAIL midrst_values: got %0d/%h/%h expected 0/000/000", err1, ffv1, {ci1, a1, b1}); end
        @(negedge clk);
        rst = 1'b0;
        mode1 = 0;
        q1.push_back(sweep_model(0, 65535, 1));
        pulse_start(1);
        wait_done(1, -1, cyc, to);
        e = q1.pop_front();
        checks++; if (to || cyc != e.cycles) begin errors++; $display("[TB] FAIL midrst_resweep_cycles: got %0d expected %0d", cyc, e.cycles); end
        checks++; if (int'(err1) != e.err || ffv1 !== e.first || pass1 !== e.pass) begin errors++; $display("[TB] FAIL midrst_resweep_result: got %0d/%h/%b expected %0d/%h/%b", err1, ffv1, pass1, e.err, e.first, e.pass); end
    endtask

    task automatic test_saturation();
        exp_t e; int cyc; bit to;
        mode2 = 1;
        q2.push_back(sweep_model(1, 15, 3));
        pulse_start(2);
        wait_done(2, -1, cyc, to);
        e = q2.pop_front();
        checks++; if (to || cyc != e.cycles) begin errors++; $display("[TB] FAIL sat_cycles: got %0d expected %0d", cyc, e.cycles); end
        checks++; if (int'(err2) != e.err) begin errors++; $display("[TB] FAIL sat_err_count: got %0d expected %0d", err2, e.err); end
        checks++; if (ffv2 !== e.first || pass2 !== e.pass) begin errors++; $display("[TB] FAIL sat_first_fail: got %h/%b expected %h/%b", ffv2, pass2, e.first, e.pass); end
    endtask

    task automatic test_settle3();
        exp_t e; int cyc; bit to;
        mode2 = 0;
        q2.push_back(sweep_model(0, 15, 3));
        pulse_start(2);
        wait_done(2, -1, cyc, to);
        e = q2.pop_front();
        checks++; if (to || cyc != e.cycles) begin errors++; $display("[TB] FAIL settle3_cycles: got %0d expected %0d", cyc, e.cycles); end
        checks++; if (int'(err2) != e.err || ffv2 !== e.first || pass2 !== e.pass || done2 !== 1'b1) begin errors++; $display("[TB] FAIL settle3_result: got %0d/%h/%b/%b expected %0d/%h/%b/1", err2, ffv2, pass2, done2, e.err, e.first, e.pass); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        monFails = 0;
        mon1     = 0;
        mon2     = 0;
        mode1    = 0;
        mode2    = 0;
        start1   = 1'b0;
        start2   = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] clean sweep");
        test_clean_sweep();
        $display("[TB] fault sweeps");
        test_fault(1, "s0_stuck");
        test_fault(2, "gg_stuck");
        test_back_to_back();
        test_restart_ignored();
        $display("[TB] reset during sweep");
        test_reset_mid_sweep();
        $display("[TB] second instance");
        test_saturation();
        test_settle3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
